des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES round-key generator that sits directly downstream of PC-1 and replaces bulk per-round key shifting. It latches the 56-bit permuted-choice-1 key (C‖D), applies the DES rotation schedule one round at a time, and emits one 48-bit PC-2 round key per handshake. The Feistel round datapath consumes these keys, one per round.

## Interface
- No parameters; the round count (16) and the rotation schedule are fixed by FIPS 46-3.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  load request; sampled only while busy=0
- decrypt  in  1  sampled with start: 1 = reverse key order (see Configuration)
- key_in  in  56  PC-1 output; key_in[55] = DES bit 1, C = key_in[55:28], D = key_in[27:0]
- rk_ready  in  1  consumer accepts rk this cycle
- rk_valid  out  1  rk holds a valid round key
- rk  out  48  PC-2(C‖D); rk[47] = DES output bit 1
- round  out  4  round index of rk minus 1 (0 = K1 … 15 = K16)
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse after the last key is accepted

## Operation
- Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C and D rotate independently as 28-bit fields.
- States are IDLE, EMIT and FIN.
- IDLE, on start:
  - Encrypt: load C‖D each rotated left by 1; round=0.
  - Decrypt: load C‖D unrotated (C16‖D16 = C0‖D0); round=15.
  - Then go to EMIT.
- EMIT: rk_valid=1 and busy=1. rk is PC-2 of the C‖D register, per the standard FIPS table.
- EMIT, on rk_valid&&rk_ready:
  - Encrypt with round<15: rotate left by S[round+2] and increment round.
  - Decrypt with round>0: rotate right by S[round+1] and decrement round.
  - Last key (encrypt round=15, decrypt round=0): go to FIN.
- FIN lasts one cycle: done=1, rk_valid=0, busy=0, then IDLE.
- start is accepted in FIN as well as in IDLE; the new run begins next cycle.
- start while busy=1 is ignored. key_in and decrypt are ignored outside the load cycle.
- rk_ready while rk_valid=0 has no effect.
- Reset, whether asynchronous or mid-run, forces:
  - state IDLE
  - C‖D register = 0
  - rk = 0, rk_valid = 0, round = 0, busy = 0, done = 0

## Timing
- Latency: start accepted in cycle t → rk_valid=1 with the first key in cycle t+1.
- Throughput: one key per cycle with rk_ready held high. 16 keys occupy cycles t+1..t+16; done=1 in t+17.
- Backpressure: while rk_valid=1 and rk_ready=0, rk and round hold stable and the C‖D register does not change.
- Final handshake in cycle u → done=1, busy=0 and rk_valid=0 in u+1. done is never asserted together with rk_valid.
- rk is a function of registered state only. There is no combinational path from any input to rk, rk_valid or round.

## Configuration
- DES_DECRYPT_EN defined:
  - The decrypt input is honoured.
  - Right-rotation logic is present.
  - Keys are emitted K16→K1.
- DES_DECRYPT_EN undefined:
  - The decrypt input is ignored and treated as 0.
  - Only left-rotation logic is built.
  - Keys are always emitted K1→K16.
  - Port list is unchanged.

## Test plan
- Encrypt: rst, then key_in=F0CCAAF556678F with start for 1 cycle and rk_ready=1. Expect the first rk=1B02EFFC7072 (round=0) the next cycle. Expect 16 consecutive keys, the last being CB3D8B0E17F5 (round=15). Expect done=1 exactly one cycle after that.
- Decrypt (DES_DECRYPT_EN defined): same key, decrypt=1. Expect the first rk=CB3D8B0E17F5 (round=15) and the last 1B02EFFC7072 (round=0), then done. With the macro undefined, the same stimulus produces the encrypt order.
- Backpressure: encrypt run with rk_ready=0 for 5 cycles at round=3. rk, round and rk_valid stay constant. The sequence resumes with round=4 and the run ends with the same K16 as the encrypt scenario.
- Ignored inputs: pulse start with key_in=00000000000000 while busy, at round=7. Also change key_in every cycle during the run. Output keys match the encrypt scenario and no restart occurs.
- Reset mid-run: assert rst asynchronously at round=9. rk, rk_valid, round, busy and done go to 0 without waiting for a clock edge. A subsequent start restarts at K1=1B02EFFC7072.
- Boundary keys and back-to-back runs:
  - key_in=0: all 16 keys are 000000000000.
  - key_in=FFFFFFFFFFFFFF: all 16 keys are FFFFFFFFFFFF.
  - start asserted in the FIN cycle: the new run's first key appears the following cycle.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES round-key generator: latches the PC-1 key (C||D), steps the rotation schedule one
// round per handshake and emits PC-2 round keys. Define DES_DECRYPT_EN for K16->K1 order.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] key_in,
    input  logic        rk_ready,
    output logic        rk_valid,
    output logic [47:0] rk,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    // PC-2 source bit (1-based DES numbering of C||D) for each output bit 1..48
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic [1:0]  state;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic        last;

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < 48; k++) begin
            r[47-k] = cd[56-PC2_TAB[k]];
        end
        return r;
    endfunction

    // Rotation amount for the key of 0-based round i is 1 in rounds 1, 2, 9 and 16, else 2
    function automatic logic two_shift(input logic [3:0] i);
        return !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
    endfunction

    function automatic logic [27:0] rol(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

`ifdef DES_DECRYPT_EN
    logic dec_q;

    function automatic logic [27:0] ror(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign last = dec_q ? (round == 4'd0) : (round == 4'd15);
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
    assign last = (round == 4'd15);
`endif

    // NOTE: outputs decode registered state only, so no input reaches rk/rk_valid/round.
    assign rk       = pc2({c_q, d_q});
    assign rk_valid = (state == EMIT);
    assign busy     = (state == EMIT);
    assign done     = (state == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            c_q   <= '0;
            d_q   <= '0;
            round <= '0;
`ifdef DES_DECRYPT_EN
            dec_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state <= EMIT;
`ifdef DES_DECRYPT_EN
                        dec_q <= decrypt;
                        if (decrypt) begin
                            // C16||D16 equals C0||D0: the total rotation is 28
                            c_q   <= key_in[55:28];
                            d_q   <= key_in[27:0];
                            round <= 4'd15;
                        end else begin
                            c_q   <= rol(key_in[55:28], 1'b0);
                            d_q   <= rol(key_in[27:0], 1'b0);
                            round <= 4'd0;
                        end
`else
                        c_q   <= rol(key_in[55:28], 1'b0);
                        d_q   <= rol(key_in[27:0], 1'b0);
                        round <= 4'd0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (last) begin
                            state <= FIN;
`ifdef DES_DECRYPT_EN
                        end else if (dec_q) begin
                            c_q   <= ror(c_q, two_shift(round));
                            d_q   <= ror(d_q, two_shift(round));
                            round <= round - 4'd1;
`endif
                        end else begin
                            c_q   <= rol(c_q, two_shift(round + 4'd1));
                            d_q   <= rol(d_q, two_shift(round + 4'd1));
                            round <= round + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key schedule.
// Expected key order follows DES_DECRYPT_EN the same way the design does.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [55:0] key_in;
    logic        rk_ready;
    logic        rk_valid;
    logic [47:0] rk;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    localparam logic [55:0] KEY = 56'hF0CCAAF556678F;

    typedef struct packed {
        logic [55:0] key;
        logic        dec;
        logic        use_std;
        logic [47:0] fill;
    } scen_t;

    logic [47:0] kstd [16];
    scen_t       scen [4];

    des_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .decrypt  (decrypt),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .round    (round),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic reversed(input scen_t s);
`ifdef DES_DECRYPT_EN
        return s.dec;
`else
        return 1'b0 & s.dec;
`endif
    endfunction

    function automatic logic [3:0] exp_round(input scen_t s, input int j);
        return reversed(s) ? 4'(15 - j) : 4'(j);
    endfunction

    function automatic logic [47:0] exp_key(input scen_t s, input int j);
        return s.use_std ? kstd[exp_round(s, j)] : s.fill;
    endfunction

    task automatic do_load(input logic [55:0] k, input logic dec);
        key_in  = k;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Walks 16 keys with rk_ready high and ends in the FIN cycle
    task automatic check_run(input scen_t s, input int idx);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("s%0d k%0d rk", idx, j), 64'(rk), 64'(exp_key(s, j)));
            check($sformatf("s%0d k%0d round", idx, j), 64'(round), 64'(exp_round(s, j)));
            check($sformatf("s%0d k%0d valid/busy/done", idx, j),
                  64'({rk_valid, busy, done}), 64'(3'b110));
            tick();
        end
        check($sformatf("s%0d fin valid/busy/done", idx), 64'({rk_valid, busy, done}), 64'(3'b001));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;

        kstd = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                 48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                 48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                 48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        scen[0] = '{key: KEY,        dec: 1'b0, use_std: 1'b1, fill: 48'h0};
        scen[1] = '{key: KEY,        dec: 1'b1, use_std: 1'b1, fill: 48'h0};
        scen[2] = '{key: 56'h0,      dec: 1'b0, use_std: 1'b0, fill: 48'h0};
        scen[3] = '{key: {56{1'b1}}, dec: 1'b0, use_std: 1'b0, fill: {48{1'b1}}};

        rst      = 1'b1;
        start    = 1'b0;
        decrypt  = 1'b0;
        rk_ready = 1'b1;
        key_in   = '0;
        tick();
        tick();
        check("reset rk", 64'(rk), 64'h0);
        check("reset valid/busy/done", 64'({rk_valid, busy, done}), 64'h0);
        check("reset round", 64'(round), 64'h0);
        rst = 1'b0;
        tick();
        check("idle after reset", 64'({rk_valid, busy, done}), 64'h0);

        for (int s = 0; s < 4; s++) begin
            do_load(scen[s].key, scen[s].dec);
            check_run(scen[s], s);
            tick();
            check($sformatf("s%0d idle", s), 64'({rk_valid, busy, done}), 64'h0);
        end

        // Backpressure at round 3 for five cycles
        do_load(KEY, 1'b0);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("bp k%0d rk", j), 64'(rk), 64'(kstd[j]));
            check($sformatf("bp k%0d round", j), 64'(round), 64'(j));
            if (j == 3) begin
                rk_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    check($sformatf("bp hold%0d rk", h), 64'(rk), 64'(kstd[3]));
                    check($sformatf("bp hold%0d round", h), 64'(round), 64'd3);
                    check($sformatf("bp hold%0d valid", h), 64'(rk_valid), 64'd1);
                end
                rk_ready = 1'b1;
            end
            tick();
        end
        check("bp done", 64'({rk_valid, busy, done}), 64'(3'b001));
        tick();

        // Ignored start and key_in changes while busy
        do_load(KEY, 1'b0);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("ign k%0d rk", j), 64'(rk), 64'(kstd[j]));
            check($sformatf("ign k%0d round", j), 64'(round), 64'(j));
            rnd    = {$urandom, $urandom};
            key_in = rnd[55:0];
            if (j == 7) begin
                start  = 1'b1;
                key_in = '0;
            end else begin
                start  = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("ign done", 64'({rk_valid, busy, done}), 64'(3'b001));
        tick();
        check("ign no restart", 64'({rk_valid, busy, done}), 64'h0);

        // Asynchronous reset mid-run at round 9
        do_load(KEY, 1'b0);
        repeat (9) tick();
        check("rst pre round", 64'(round), 64'd9);
        #2;
        rst = 1'b1;
        #1;
        check("async rst rk", 64'(rk), 64'h0);
        check("async rst round", 64'(round), 64'h0);
        check("async rst valid/busy/done", 64'({rk_valid, busy, done}), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        do_load(KEY, 1'b0);
        check_run(scen[0], 10);

        // start in the FIN cycle chains a new run
        key_in = KEY;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("fin restart rk", 64'(rk), 64'(kstd[0]));
        check("fin restart round", 64'(round), 64'd0);
        check("fin restart valid/done", 64'({rk_valid, done}), 64'(2'b10));
        repeat (15) tick();
        check("fin restart last rk", 64'(rk), 64'(kstd[15]));
        tick();
        check("fin restart done", 64'({rk_valid, busy, done}), 64'(3'b001));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
